// File: rtl/am2910p_pkg.sv
// Shared opcode encoding and condition helper for the Am2910-class sequencer.
package am2910p_pkg;

    typedef enum logic [3:0] {
        OP_JZ   = 4'd0,
        OP_CJS  = 4'd1,
        OP_JMAP = 4'd2,
        OP_CJP  = 4'd3,
        OP_PUSH = 4'd4,
        OP_JSRP = 4'd5,
        OP_CJV  = 4'd6,
        OP_JRP  = 4'd7,
        OP_RFCT = 4'd8,
        OP_RPCT = 4'd9,
        OP_CRTN = 4'd10,
        OP_CJPP = 4'd11,
        OP_LDCT = 4'd12,
        OP_LOOP = 4'd13,
        OP_CONT = 4'd14,
        OP_TWB  = 4'd15
    } opcode_t;

    // A disabled condition (ccen_ high) always counts as a pass.
    function automatic logic cond_pass(input logic cc_, input logic ccen_);
        return ccen_ | ~cc_;
    endfunction

endpackage

// File: rtl/am2910p_stack.sv
// DEPTH x WIDTH LIFO holding subroutine return addresses and loop starts.
module am2910p_stack
    import am2910p_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full_
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    logic [WIDTH-1:0] r_mem [0:(1 << SPW) - 1];
    logic [SPW-1:0]   r_sp;
    logic             w_full;
    logic [SPW-1:0]   w_wr_idx;

    assign w_full   = (r_sp == SP_FULL);
    // A push onto a full stack overwrites the newest entry instead of growing.
    assign w_wr_idx = w_full ? SP_FULL - SPW'(1) : r_sp;
    assign full_    = ~w_full;
    assign top      = (r_sp == '0) ? '0 : r_mem[r_sp - SPW'(1)];

    always_ff @(posedge clk) begin
        if (clr) begin
            r_sp <= '0;
        end else if (push) begin
            if (!w_full) r_sp <= r_sp + SPW'(1);
        end else if (pop) begin
            if (r_sp != '0) r_sp <= r_sp - SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) r_mem[w_wr_idx] <= din;
    end

endmodule

// File: rtl/am2910p_seq.sv
// Am2910-class microprogram sequencer: next-address decode, uPC, loop counter R and return stack.
module am2910p_seq
    import am2910p_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [3:0]       i,
    input  logic [WIDTH-1:0] d,
    input  logic             cc_,
    input  logic             ccen_,
    input  logic             rld_,
    input  logic             ci,
    input  logic             oe_,
    output logic [WIDTH-1:0] y,
    output logic             full_,
    output logic             pl_,
    output logic             map_,
    output logic             vect_
);

    logic [WIDTH-1:0] r_upc;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_top;
    logic             w_pass;
    logic             w_r0;
    logic             w_push;
    logic             w_pop;
    logic             w_jz;
    logic             w_ld_r;
    logic             w_dec_r;
    opcode_t          w_op;

    assign w_op   = opcode_t'(i);
    assign w_pass = cond_pass(cc_, ccen_);
    assign w_r0   = (r_r == '0);

    always_comb begin
        w_y     = r_upc;
        w_push  = 1'b0;
        w_pop   = 1'b0;
        w_jz    = 1'b0;
        w_ld_r  = 1'b0;
        w_dec_r = 1'b0;
        case (w_op)
            OP_JZ:   begin w_y = '0; w_jz = 1'b1; end
            OP_CJS:  if (w_pass) begin w_y = d; w_push = 1'b1; end
            OP_JMAP: w_y = d;
            OP_CJP:  if (w_pass) w_y = d;
            OP_PUSH: begin w_push = 1'b1; w_ld_r = w_pass; end
            OP_JSRP: begin w_y = w_pass ? d : r_r; w_push = 1'b1; end
            OP_CJV:  if (w_pass) w_y = d;
            OP_JRP:  w_y = w_pass ? d : r_r;
            OP_RFCT: if (!w_r0) begin w_y = w_top; w_dec_r = 1'b1; end
                     else w_pop = 1'b1;
            OP_RPCT: if (!w_r0) begin w_y = d; w_dec_r = 1'b1; end
            OP_CRTN: if (w_pass) begin w_y = w_top; w_pop = 1'b1; end
            OP_CJPP: if (w_pass) begin w_y = d; w_pop = 1'b1; end
            OP_LDCT: w_ld_r = 1'b1;
            OP_LOOP: if (w_pass) w_pop = 1'b1;
                     else w_y = w_top;
            OP_CONT: w_y = r_upc;
            OP_TWB: begin
                // Only the counting-and-failing case stays in the loop without popping.
                if (!w_r0 && !w_pass) begin
                    w_y     = w_top;
                    w_dec_r = 1'b1;
                end else begin
                    w_y   = (w_r0 && !w_pass) ? d : r_upc;
                    w_pop = 1'b1;
                end
            end
        endcase
    end

    am2910p_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .push  (w_push),
        .pop   (w_pop),
        .clr   (w_jz | ~rst_),
        .din   (r_upc),
        .top   (w_top),
        .full_ (full_)
    );

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_upc <= '0;
            r_r   <= '0;
        end else begin
            r_upc <= w_y + {{(WIDTH-1){1'b0}}, ci};
            if (!rld_ || w_ld_r) r_r <= d;
            else if (w_dec_r)   r_r <= r_r - WIDTH'(1);
        end
    end

    assign y     = oe_ ? {WIDTH{1'bz}} : w_y;
    assign pl_   = (w_op == OP_JMAP) || (w_op == OP_CJV);
    assign map_  = (w_op != OP_JMAP);
    assign vect_ = (w_op != OP_CJV);

endmodule

// File: tb/tb_am2910p_seq.sv
// Directed vector bench for am2910p_seq (WIDTH=12, DEPTH=5).
module tb_am2910p_seq;

    localparam int W = 12;

    localparam logic [1:0] P   = 2'b00;
    localparam logic [1:0] F   = 2'b10;
    localparam logic [1:0] FRC = 2'b11;

    typedef struct {
        logic         rst_;
        logic [3:0]   op;
        logic [W-1:0] d;
        logic [1:0]   cc;
        logic         rld_;
        logic         ci;
        logic         chk_y;
        logic [W-1:0] y;
        logic         chk_full;
        logic         full_;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_ = 1'b0;
    logic [3:0]   i = 4'd14;
    logic [W-1:0] d = '0;
    logic         cc_ = 1'b0;
    logic         ccen_ = 1'b0;
    logic         rld_ = 1'b1;
    logic         ci = 1'b1;
    logic         oe_ = 1'b0;
    wire  [W-1:0] y;
    wire          full_;
    wire          pl_;
    wire          map_;
    wire          vect_;

    int n_chk = 0;
    int n_err = 0;
    vec_t tv[$];

    am2910p_seq #(.WIDTH(W), .DEPTH(5)) dut (
        .clk   (clk),
        .rst_  (rst_),
        .i     (i),
        .d     (d),
        .cc_   (cc_),
        .ccen_ (ccen_),
        .rld_  (rld_),
        .ci    (ci),
        .oe_   (oe_),
        .y     (y),
        .full_ (full_),
        .pl_   (pl_),
        .map_  (map_),
        .vect_ (vect_)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] op, input logic [W-1:0] dd,
                                input logic [1:0] cc, input logic rl, input logic c,
                                input logic cy, input logic [W-1:0] ey,
                                input logic cf, input logic ef);
        vec_t v;
        v.rst_ = r; v.op = op; v.d = dd; v.cc = cc; v.rld_ = rl; v.ci = c;
        v.chk_y = cy; v.y = ey; v.chk_full = cf; v.full_ = ef;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] op, input logic [W-1:0] dd,
                         input logic [1:0] cc, input logic rl, input logic c, input logic oe);
        @(negedge clk);
        rst_ = r; i = op; d = dd; cc_ = cc[1]; ccen_ = cc[0]; rld_ = rl; ci = c; oe_ = oe;
        #1;
    endtask

    task automatic chk_dec(input string nm, input logic [3:0] op);
        chk({nm, ".pl_"},   W'(pl_),   W'(op == 4'd2 || op == 4'd6));
        chk({nm, ".map_"},  W'(map_),  W'(op != 4'd2));
        chk({nm, ".vect_"}, W'(vect_), W'(op != 4'd6));
    endtask

    initial begin
        // reset, then CONT x3 from uPC=0
        tv.push_back(mk(0, 14, 12'h000, P,  1, 1, 0, 12'h000, 0, 1));
        tv.push_back(mk(1, 14, 12'h000, P,  1, 1, 1, 12'h000, 1, 1));
        tv.push_back(mk(1, 14, 12'h000, P,  1, 1, 1, 12'h001, 1, 1));
        tv.push_back(mk(1, 14, 12'h000, P,  1, 1, 1, 12'h002, 1, 1));
        tv.push_back(mk(1, 14, 12'h000, P,  1, 1, 1, 12'h003, 1, 1));
        // LDCT 3 then RPCT x4
        tv.push_back(mk(1, 12, 12'h003, P,  1, 1, 1, 12'h004, 1, 1));
        tv.push_back(mk(1,  9, 12'h100, P,  1, 1, 1, 12'h100, 1, 1));
        tv.push_back(mk(1,  9, 12'h100, P,  1, 1, 1, 12'h100, 1, 1));
        tv.push_back(mk(1,  9, 12'h100, P,  1, 1, 1, 12'h100, 1, 1));
        tv.push_back(mk(1,  9, 12'h100, P,  1, 1, 1, 12'h101, 1, 1));
        tv.push_back(mk(1,  7, 12'h0AB, F,  1, 1, 1, 12'h000, 1, 1));
        // subroutine call at address 5 and return to 6
        tv.push_back(mk(1,  3, 12'h005, P,  1, 1, 1, 12'h005, 1, 1));
        tv.push_back(mk(1,  1, 12'h200, P,  1, 1, 1, 12'h200, 1, 1));
        tv.push_back(mk(1, 10, 12'h000, P,  1, 1, 1, 12'h006, 1, 1));
        tv.push_back(mk(1, 10, 12'h000, P,  1, 1, 1, 12'h000, 1, 1));
        // PUSH x6: fill, then overwrite top
        tv.push_back(mk(1,  4, 12'h000, F,  1, 1, 1, 12'h001, 1, 1));
        tv.push_back(mk(1,  4, 12'h000, F,  1, 1, 1, 12'h002, 1, 1));
        tv.push_back(mk(1,  4, 12'h000, F,  1, 1, 1, 12'h003, 1, 1));
        tv.push_back(mk(1,  4, 12'h000, F,  1, 1, 1, 12'h004, 1, 1));
        tv.push_back(mk(1,  4, 12'h000, F,  1, 1, 1, 12'h005, 1, 1));
        tv.push_back(mk(1,  4, 12'h000, F,  1, 1, 1, 12'h006, 1, 0));
        tv.push_back(mk(1, 13, 12'h000, F,  1, 1, 1, 12'h006, 1, 0));
        tv.push_back(mk(1, 10, 12'h000, P,  1, 1, 1, 12'h006, 1, 0));
        tv.push_back(mk(1, 10, 12'h000, P,  1, 1, 1, 12'h004, 1, 1));
        tv.push_back(mk(1,  0, 12'h0FF, P,  1, 1, 1, 12'h000, 1, 1));
        tv.push_back(mk(1, 10, 12'h000, P,  1, 1, 1, 12'h000, 1, 1));
        // map / vector enables and condition handling
        tv.push_back(mk(1,  2, 12'h3C5, P,  1, 1, 1, 12'h3C5, 1, 1));
        tv.push_back(mk(1,  6, 12'h007, F,  1, 1, 1, 12'h3C6, 1, 1));
        tv.push_back(mk(1,  3, 12'h0AA, FRC,1, 1, 1, 12'h0AA, 1, 1));
        tv.push_back(mk(1,  3, 12'h055, F,  1, 1, 1, 12'h0AB, 1, 1));
        tv.push_back(mk(1, 14, 12'h000, P,  1, 0, 1, 12'h0AC, 1, 1));
        tv.push_back(mk(1, 14, 12'h000, P,  1, 1, 1, 12'h0AC, 1, 1));
        // rld_ overrides the RPCT decrement
        tv.push_back(mk(1, 12, 12'h002, P,  1, 1, 1, 12'h0AD, 1, 1));
        tv.push_back(mk(1,  9, 12'h300, P,  0, 1, 1, 12'h300, 1, 1));
        tv.push_back(mk(1,  7, 12'h111, F,  1, 1, 1, 12'h300, 1, 1));
        tv.push_back(mk(1,  5, 12'h222, F,  1, 1, 1, 12'h300, 1, 1));
        tv.push_back(mk(1, 10, 12'h000, P,  1, 1, 1, 12'h301, 1, 1));
        // TWB with R counting down to zero
        tv.push_back(mk(1, 12, 12'h001, P,  1, 1, 1, 12'h302, 1, 1));
        tv.push_back(mk(1,  4, 12'h000, F,  1, 1, 1, 12'h303, 1, 1));
        tv.push_back(mk(1, 15, 12'h0F0, F,  1, 1, 1, 12'h303, 1, 1));
        tv.push_back(mk(1, 15, 12'h0F0, F,  1, 1, 1, 12'h0F0, 1, 1));
        tv.push_back(mk(1, 10, 12'h000, P,  1, 1, 1, 12'h000, 1, 1));
        // CJPP pops
        tv.push_back(mk(1,  4, 12'h000, F,  1, 1, 1, 12'h001, 1, 1));
        tv.push_back(mk(1, 11, 12'h055, P,  1, 1, 1, 12'h055, 1, 1));
        tv.push_back(mk(1, 10, 12'h000, P,  1, 1, 1, 12'h000, 1, 1));
        // RFCT loop exit and LOOP pass
        tv.push_back(mk(1, 12, 12'h001, P,  1, 1, 1, 12'h001, 1, 1));
        tv.push_back(mk(1,  4, 12'h000, F,  1, 1, 1, 12'h002, 1, 1));
        tv.push_back(mk(1,  8, 12'h000, P,  1, 1, 1, 12'h002, 1, 1));
        tv.push_back(mk(1,  8, 12'h000, P,  1, 1, 1, 12'h003, 1, 1));
        tv.push_back(mk(1, 10, 12'h000, P,  1, 1, 1, 12'h000, 1, 1));
        tv.push_back(mk(1,  4, 12'h000, F,  1, 1, 1, 12'h001, 1, 1));
        tv.push_back(mk(1, 13, 12'h000, P,  1, 1, 1, 12'h002, 1, 1));
        tv.push_back(mk(1, 10, 12'h000, P,  1, 1, 1, 12'h000, 1, 1));
        // PUSH pass loads R; TWB counting pass exits
        tv.push_back(mk(1,  4, 12'h007, P,  1, 1, 1, 12'h001, 1, 1));
        tv.push_back(mk(1,  7, 12'h000, F,  1, 1, 1, 12'h007, 1, 1));
        tv.push_back(mk(1, 15, 12'h0F0, P,  1, 1, 1, 12'h008, 1, 1));
        tv.push_back(mk(1, 10, 12'h000, P,  1, 1, 1, 12'h000, 1, 1));

        for (int k = 0; k < tv.size(); k++) begin
            drive(tv[k].rst_, tv[k].op, tv[k].d, tv[k].cc, tv[k].rld_, tv[k].ci, 1'b0);
            if (tv[k].chk_y)    chk($sformatf("v%0d.y", k), y, tv[k].y);
            if (tv[k].chk_full) chk($sformatf("v%0d.full_", k), W'(full_), W'(tv[k].full_));
            chk_dec($sformatf("v%0d", k), tv[k].op);
        end

        // reset in the middle of an RFCT loop (uPC=1 here)
        drive(1, 12, 12'h005, P, 1, 1, 0); chk("rst.ldct.y", y, 12'h001);
        drive(1,  4, 12'h000, F, 1, 1, 0); chk("rst.push.y", y, 12'h002);
        drive(1,  8, 12'h000, P, 1, 1, 0); chk("rst.rfct1.y", y, 12'h002);
        drive(1,  8, 12'h000, P, 1, 1, 0); chk("rst.rfct2.y", y, 12'h002);
        drive(0,  8, 12'h000, P, 1, 1, 0); chk("rst.rfct3.y", y, 12'h002);
        drive(1, 14, 12'h000, P, 1, 1, 0); chk("rst.upc", y, 12'h000);
        chk("rst.full_", W'(full_), W'(1'b1));
        drive(1,  7, 12'h123, F, 1, 1, 0); chk("rst.r", y, 12'h000);
        drive(1, 10, 12'h000, P, 1, 1, 0); chk("rst.sp", y, 12'h000);

        // output enable: uPC=1 here, so a driven y would read 1
        drive(1, 14, 12'h000, P, 1, 1, 1);
        n_chk++;
        if (!((y === {W{1'bz}}) || (y == '0))) begin
            n_err++;
            $display("FAIL oe.hiz got=%h expected=zzz", y);
        end
        drive(1, 14, 12'h000, P, 1, 1, 0); chk("oe.drive", y, 12'h002);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
